vector_mac_stream: RTL and testbench

Streaming successor to the combinational element-wise multiplier. It accepts N-lane packed vector beats over a valid/ready handshake and multiplies lanes in a registered pipeline. It runs in one of two modes. In element-wise mode it outputs the per-lane products. In dot mode it reduces and accumulates products across a multi-beat packet into one dot-product result. It sits between the vector source (memory reader or bench) and the result sink in the dot-product datapath.

---
 rtl/vector_mac_stream.sv | 174 +++++++++++++++++
 tb/tb_vector_mac_stream.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mac_stream.sv
// vector_mac_stream
//   Streaming N-lane vector multiplier with two output modes:
//     - element-wise (mode=0): one result per beat, c lane i = low W bits of a_i*b_i
//     - dot product  (mode=1): lane products are summed and accumulated across a
//       packet; a single result with the full dot product is emitted on in_last.
//   Two register stages: S1 holds the full-width lane products, S2 is the output
//   register (and owns the dot accumulator).
//
// Ports
//   clk, rst      : clock (rising edge), synchronous active-high reset
//   mode          : 0 = element-wise, 1 = dot; captured on the first beat of a packet
//   in_valid      : input beat valid
//   in_ready      : block can accept a beat (low only while the output is stalled)
//   in_last       : last beat of a dot packet (ignored in element-wise mode)
//   a, b          : packed input vectors, lane i = x[W*i +: W], unsigned
//   out_valid     : result valid
//   out_ready     : sink accepts result
//   out_mode      : mode of the presented result
//   c             : element-wise products (0 in dot results)
//   dot           : dot-product result modulo 2^ACC_W (0 in element-wise results)
//   overflow      : dot result wrapped modulo 2^ACC_W at some point in its packet
module vector_mac_stream #(
    parameter int N     = 8,
    parameter int W     = 32,
    parameter int ACC_W = 80
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [W*N-1:0]     a,
    input  logic [W*N-1:0]     b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_mode,
    output logic [W*N-1:0]     c,
    output logic [ACC_W-1:0]   dot,
    output logic               overflow
);

    // Headroom: the beat sum can exceed 2^ACC_W on its own when ACC_W == 2W,
    // so the accumulate is done wide enough that every wrap shows up as
    // non-zero bits above ACC_W.
    localparam int LG_N  = (N > 1) ? $clog2(N) : 1;
    localparam int TOT_W = ACC_W + LG_N + 1;

    // Sum of the N full-width lane products, zero-extended.
    function automatic logic [TOT_W-1:0] beat_sum(input logic [2*W*N-1:0] p);
        logic [TOT_W-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++) begin
            s = s + TOT_W'(p[2*W*i +: 2*W]);
        end
        return s;
    endfunction

    // Element-wise result: each product wraps to its low W bits.
    function automatic logic [W*N-1:0] lane_wrap(input logic [2*W*N-1:0] p);
        logic [W*N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[W*i +: W] = p[2*W*i +: W];
        end
        return r;
    endfunction

    logic               stall;
    logic               accept;
    logic               pkt_open;
    logic               mode_lat;
    logic               eff_mode;
    logic               eff_last;

    logic [2*W*N-1:0]   prod_p0;
    logic [2*W*N-1:0]   prod_p1;
    logic               vld_p1;
    logic               mode_p1;
    logic               last_p1;

    logic [ACC_W-1:0]   acc_p2;
    logic               sticky_p2;
    logic [TOT_W-1:0]   tot_p2;
    logic               carry_p2;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    // Mode is only honoured on the opening beat; an element-wise beat always
    // closes its packet so in_last is irrelevant there.
    assign eff_mode = pkt_open ? mode_lat : mode;
    assign eff_last = ~eff_mode | in_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_open <= 1'b0;
            mode_lat <= 1'b0;
        end else if (accept) begin
            pkt_open <= ~eff_last;
            if (!pkt_open) begin
                mode_lat <= mode;
            end
        end
    end

    always_comb begin
        prod_p0 = '0;
        for (int i = 0; i < N; i++) begin
            prod_p0[2*W*i +: 2*W] = (2*W)'(a[W*i +: W]) * (2*W)'(b[W*i +: W]);
        end
    end

    // ---- stage 0 -> stage 1: lane products ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            mode_p1 <= 1'b0;
            last_p1 <= 1'b0;
        end else if (!stall) begin
            vld_p1  <= accept;
            mode_p1 <= eff_mode;
            last_p1 <= eff_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            prod_p1 <= prod_p0;
        end
    end

    always_comb begin
        tot_p2   = TOT_W'(acc_p2) + beat_sum(prod_p1);
        carry_p2 = |tot_p2[TOT_W-1:ACC_W];
    end

    // ---- stage 1 -> stage 2: accumulate / output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            c         <= '0;
            dot       <= '0;
            overflow  <= 1'b0;
            acc_p2    <= '0;
            sticky_p2 <= 1'b0;
        end else if (!stall) begin
            if (!vld_p1) begin
                out_valid <= 1'b0;
            end else if (!mode_p1) begin
                out_valid <= 1'b1;
                out_mode  <= 1'b0;
                c         <= lane_wrap(prod_p1);
                dot       <= '0;
                overflow  <= 1'b0;
            end else if (last_p1) begin
                out_valid <= 1'b1;
                out_mode  <= 1'b1;
                c         <= '0;
                dot       <= tot_p2[ACC_W-1:0];
                overflow  <= sticky_p2 | carry_p2;
                acc_p2    <= '0;
                sticky_p2 <= 1'b0;
            end else begin
                out_valid <= 1'b0;
                acc_p2    <= tot_p2[ACC_W-1:0];
                sticky_p2 <= sticky_p2 | carry_p2;
            end
        end
    end

endmodule

// File: tb/tb_vector_mac_stream.sv
module tb_vector_mac_stream;

    localparam int N     = 8;
    localparam int W     = 32;
    localparam int ACC_W = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               mode;
    logic               in_valid;
    logic               in_ready;
    logic               in_last;
    logic [W*N-1:0]     a;
    logic [W*N-1:0]     b;
    logic               out_valid;
    logic               out_ready;
    logic               out_mode;
    logic [W*N-1:0]     c;
    logic [ACC_W-1:0]   dot;
    logic               overflow;

    vector_mac_stream #(.N(N), .W(W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .c         (c),
        .dot       (dot),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           m;
        logic [255:0]   cv;
        logic [63:0]    d;
        logic           o;
    } exp_t;

    exp_t           sb[$];
    int             n_checks  = 0;
    int             n_fail    = 0;
    int             n_results = 0;

    logic           m_open = 1'b0;
    logic           m_mode = 1'b0;
    logic [127:0]   m_acc  = '0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] ramp(input int mul);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[32*i +: 32] = 32'((i + 1) * mul);
        return v;
    endfunction

    // Reference model of one accepted beat; pushes a result when one is due.
    task automatic model_accept(input logic md, input logic lst,
                                input logic [255:0] va, input logic [255:0] vb);
        logic         em, el;
        logic [127:0] p;
        exp_t         e;
        em = m_open ? m_mode : md;
        if (!m_open) m_mode = md;
        el = !em || lst;
        if (!em) begin
            e.m = 1'b0; e.cv = '0; e.d = '0; e.o = 1'b0;
            for (int i = 0; i < N; i++) begin
                p = 128'(va[32*i +: 32]) * 128'(vb[32*i +: 32]);
                e.cv[32*i +: 32] = p[31:0];
            end
            sb.push_back(e);
        end else begin
            for (int i = 0; i < N; i++) begin
                p = 128'(va[32*i +: 32]) * 128'(vb[32*i +: 32]);
                m_acc = m_acc + p;
            end
            if (el) begin
                e.m = 1'b1; e.cv = '0; e.d = m_acc[63:0]; e.o = |m_acc[127:64];
                sb.push_back(e);
                m_acc = '0;
            end
        end
        m_open = !el;
    endtask

    task automatic send(input logic md, input logic lst,
                        input logic [255:0] va, input logic [255:0] vb);
        logic rdy, done;
        done = 1'b0;
        rdy  = 1'b0;
        a = va; b = vb; mode = md; in_last = lst; in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) done = 1'b1;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 256'(rdy), 256'(1));
        else model_accept(md, lst, va, vb);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 256'(out_valid), 256'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_mode", 256'(out_mode), 256'(e.m));
                check("res_c",    c,              e.cv);
                check("res_dot",  256'(dot),      256'(e.d));
                check("res_ovf",  256'(overflow), 256'(e.o));
            end
            n_results++;
        end
    end

    initial begin
        logic [255:0] held;
        logic [255:0] ones;
        held = '0;
        ones = '1;
        rst = 1'b1; in_valid = 1'b0; mode = 1'b0; in_last = 1'b0;
        a = '0; b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_in_ready",  256'(in_ready),  256'(1));
        check("rst_c",         c,               256'(0));
        check("rst_dot",       256'(dot),       256'(0));
        check("rst_ovf",       256'(overflow),  256'(0));
        check("rst_out_mode",  256'(out_mode),  256'(0));
        @(posedge clk); #1;

        // element-wise single beat with latency check
        send(1'b0, 1'b0, ramp(1), ramp(2));
        @(negedge clk);
        check("ew_lat_t1", 256'(out_valid), 256'(0));
        @(negedge clk);
        check("ew_lat_t2", 256'(out_valid), 256'(1));
        @(posedge clk); #1;

        // single-beat dot packet, one-cycle output pulse
        send(1'b1, 1'b1, ramp(1), ramp(2));
        @(negedge clk);
        check("dot1_lat_t1", 256'(out_valid), 256'(0));
        @(negedge clk);
        check("dot1_valid", 256'(out_valid), 256'(1));
        check("dot1_value", 256'(dot),       256'(408));
        @(negedge clk);
        check("dot1_one_cycle", 256'(out_valid), 256'(0));
        @(posedge clk); #1;

        // two-beat packet followed back-to-back by a single-beat packet
        send(1'b1, 1'b0, ramp(1), ramp(2));
        send(1'b1, 1'b1, ramp(1), ramp(2));
        send(1'b1, 1'b1, ramp(1), ramp(2));
        repeat (4) @(posedge clk); #1;

        // backpressure: 4 element-wise beats, sink stalls 3 cycles
        fork
            begin
                for (int k = 0; k < 4; k++) send(1'b0, 1'b0, ramp(k + 1), ramp(k + 3));
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("stall_in_ready",  256'(in_ready),  256'(0));
                    check("stall_out_valid", 256'(out_valid), 256'(1));
                    if (k == 0) held = c;
                    else        check("stall_c_held", c, held);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk); #1;

        // overflow then a clean packet
        send(1'b1, 1'b1, ones, ones);
        @(negedge clk);
        @(negedge clk);
        check("ovf_dot",  256'(dot),      256'(64'hFFFF_FFF0_0000_0008));
        check("ovf_flag", 256'(overflow), 256'(1));
        @(posedge clk); #1;
        send(1'b1, 1'b1, ramp(1), ramp(2));
        repeat (4) @(posedge clk); #1;

        // reset in the middle of a dot packet
        send(1'b1, 1'b0, ramp(1), ramp(2));
        rst = 1'b1;
        m_open = 1'b0;
        m_acc  = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 256'(out_valid), 256'(0));
        check("midrst_in_ready",  256'(in_ready),  256'(1));
        @(posedge clk); #1;
        send(1'b1, 1'b1, ramp(1), ramp(2));
        repeat (4) @(posedge clk); #1;

        // mode toggled inside a 3-beat dot packet
        send(1'b1, 1'b0, ramp(1), ramp(2));
        send(1'b0, 1'b0, ramp(1), ramp(2));
        send(1'b1, 1'b1, ramp(1), ramp(2));

        for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("drain",        256'(sb.size()), 256'(0));
        check("result_count", 256'(n_results), 256'(12));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
